// File: rtl/fp32_mul_arbiter.sv
// fp32_mul_arbiter: round-robin sharing of one external FP32 multiplier among
// NUM_REQ requesters. A granted operand pair is held on mul_a/mul_b for the
// multiplier latency, the packed result is captured and queued together with
// the owning requester index in a small response FIFO.
module fp32_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int MUL_LATENCY = 1,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                  clk_n,
  input  logic                  rst_n,        // synchronous, active-high
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic                  mul_sign,
  input  logic [7:0]            mul_exponent,
  input  logic [22:0]           mul_mantissa,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  busy
);

  localparam int CNT_W = (MUL_LATENCY < 2) ? 1 : $clog2(MUL_LATENCY + 1);
  localparam int PTR_W = (RSP_DEPTH < 2) ? 1 : $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_CAPTURE
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } rsp_entry_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;

  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic             accept;

  rsp_entry_t       fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_full;
  logic             push, pop;

  assign fifo_full = (fifo_count == (PTR_W + 1)'(RSP_DEPTH));
  assign push      = (state == ST_CAPTURE);
  assign pop       = rsp_valid & rsp_ready;
  assign accept    = |(req_valid & req_ready);

  // Round-robin scan from rr_ptr; grant only in IDLE with a free FIFO slot.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    req_ready   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // NOTE: blocking assignments in combinational logic; the loop relies on
      // seeing grant_found updated within the same evaluation.
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    if ((state == ST_IDLE) && !fifo_full && !rst_n && grant_found)
      req_ready[grant_id] = 1'b1;
  end

  // Next-state logic: IDLE -> HOLD on accept, HOLD for MUL_LATENCY cycles,
  // one CAPTURE cycle, back to IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end
      end
      ST_HOLD: begin
        cnt_next = cnt + 1'b1;
        if (cnt + 1'b1 == CNT_W'(MUL_LATENCY))
          state_next = ST_CAPTURE;
      end
      ST_CAPTURE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State and hold-counter registers.
  always_ff @(posedge clk_n) begin
    if (rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Operand, owner and round-robin pointer registers, loaded only on accept so
  // the multiplier inputs stay stable through HOLD and CAPTURE.
  always_ff @(posedge clk_n) begin
    if (rst_n) begin
      mul_a  <= '0;
      mul_b  <= '0;
      cur_id <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      mul_a  <= req_a[32*int'(grant_id) +: 32];
      mul_b  <= req_b[32*int'(grant_id) +: 32];
      cur_id <= grant_id;
      if (int'(grant_id) == NUM_REQ - 1)
        rr_ptr <= '0;
      else
        rr_ptr <= grant_id + 1'b1;
    end
  end

  // Response storage written at the CAPTURE edge.
  always_ff @(posedge clk_n) begin
    // NOTE: the storage array has no reset; the pointers and count define which
    // entries are live, and the output is forced to zero while empty.
    if (push)
      fifo_mem[wr_ptr] <= '{id: cur_id, data: {mul_sign, mul_exponent, mul_mantissa}};
  end

  // FIFO pointers and occupancy; reset discards any queued responses.
  always_ff @(posedge clk_n) begin
    if (rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_id    = rsp_valid ? fifo_mem[rd_ptr].id   : '0;
  assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr].data : '0;
  assign busy      = (state != ST_IDLE) || rsp_valid;

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Directed bench for fp32_mul_arbiter. The external multiplier is stood in by
// a small behavioural model (truncating FP32 multiply that returns zero
// magnitude when either mantissa field is zero).
module tb_fp32_mul_arbiter;

  logic         clk_n;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [31:0]  mul_a;
  logic [31:0]  mul_b;
  logic         mul_sign;
  logic [7:0]   mul_exponent;
  logic [22:0]  mul_mantissa;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          g_id[$];
  int          g_cyc[$];
  int          r_id[$];
  logic [31:0] r_data[$];

  fp32_mul_arbiter #(
    .NUM_REQ(4), .ID_W(2), .MUL_LATENCY(1), .RSP_DEPTH(4)
  ) dut (
    .clk_n(clk_n), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign(mul_sign), .mul_exponent(mul_exponent), .mul_mantissa(mul_mantissa),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk_n = 1'b0;
  always #5 clk_n = ~clk_n;

  always @(posedge clk_n) cyc <= cyc + 1;

  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    if (a[22:0] == 23'd0 || b[22:0] == 23'd0)
      return {a[31] ^ b[31], 31'd0};
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  always_comb {mul_sign, mul_exponent, mul_mantissa} = mul_model(mul_a, mul_b);

  // Record grants and consumed responses mid-cycle, away from the active edge.
  always @(negedge clk_n) begin
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) begin
        g_id.push_back(i);
        g_cyc.push_back(cyc);
      end
    if (rsp_valid && rsp_ready) begin
      r_id.push_back(int'(rsp_id));
      r_data.push_back(rsp_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_n);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    set_op(i, a, b);
    req_valid = 4'(1 << i);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
    tick();
    req_valid = 4'b0000;
    wait_rsp(tag);
    check({tag, "_id"}, 32'(rsp_id), 32'(i));
    check({tag, "_data"}, rsp_data, exp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_grant [5];
    logic [31:0] exp_data [4];
    exp_grant = '{0, 1, 2, 3, 0};
    exp_data  = '{32'h40100000, 32'hC0100000, 32'h40900000, 32'h3F900000};

    rst_n     = 1'b1;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();

    // Requests while reset is asserted are never granted.
    req_valid = 4'hF;
    #1;
    check("ready_in_reset", 32'(req_ready), 32'd0);
    tick();
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single op from requester 2, cycle-exact latency.
    set_op(2, 32'h3FC00000, 32'h3FC00000);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    tick();
    check("single_mul_a", mul_a, 32'h3FC00000);
    check("single_mul_b", mul_b, 32'h3FC00000);
    check("single_busy", 32'(busy), 32'd1);
    check("single_ready_hold", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    tick();
    check("single_rsp_e1", 32'(rsp_valid), 32'd0);
    tick();
    check("single_rsp_e2", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd2);
    check("single_data", rsp_data, 32'h40100000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("single_popped", 32'(rsp_valid), 32'd0);
    check("single_idle", 32'(busy), 32'd0);

    // Sign and zero-mantissa passthrough.
    run_op("sign", 0, 32'hBFC00000, 32'h3FC00000, 32'hC0100000);
    run_op("zero_mant", 1, 32'h3FC00000, 32'h40000000, 32'h00000000);

    // Reset during HOLD drops the operation and rewinds the pointer.
    set_op(1, 32'h3FC00000, 32'h3FC00000);
    req_valid = 4'b0010;
    #1;
    check("midrst_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    tick();
    rst_n = 1'b0;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_mul_a", mul_a, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    tick();
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);

    // Round-robin with all requesters active and no backpressure.
    for (int i = 0; i < 4; i++) set_op(i, 32'h3FC00000, 32'h3FC00000);
    set_op(1, 32'h3FC00000, 32'hBFC00000);
    set_op(2, 32'h3FC00000, 32'h40400000);
    set_op(3, 32'h3FC00000, 32'h3F400000);
    g_id.delete();
    g_cyc.delete();
    r_id.delete();
    r_data.delete();
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    check("rr_first_grant", 32'(req_ready), 32'b0001);
    for (int t = 0; t < 13; t++) tick();
    req_valid = 4'b0000;
    for (int t = 0; t < 6; t++) tick();
    check("rr_grant_count", 32'(g_id.size()), 32'd5);
    check("rr_rsp_count", 32'(r_id.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_grant%0d", k), 32'(k < g_id.size() ? g_id[k] : -1), 32'(exp_grant[k]));
      check($sformatf("rr_rsp_id%0d", k), 32'(k < r_id.size() ? r_id[k] : -1), 32'(exp_grant[k]));
      check($sformatf("rr_rsp_data%0d", k), k < r_data.size() ? r_data[k] : 32'hDEADBEEF,
            exp_data[exp_grant[k]]);
      if (k > 0)
        check($sformatf("rr_spacing%0d", k),
              32'(k < g_cyc.size() ? g_cyc[k] - g_cyc[k-1] : -1), 32'd3);
    end

    // Backpressure: four accepts fill the FIFO, then grants stop.
    g_id.delete();
    r_id.delete();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int t = 0; t < 20; t++) tick();
    check("bp_grant_count", 32'(g_id.size()), 32'd4);
    check("bp_ready_full", 32'(req_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_head_id", 32'(rsp_id), 32'd1);
    g_id.delete();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_head_after_pop", 32'(rsp_id), 32'd2);
    check("bp_ready_after_pop", 32'(req_ready), 32'b0010);
    for (int t = 0; t < 10; t++) tick();
    check("bp_one_more_grant", 32'(g_id.size()), 32'd1);
    check("bp_one_pop", 32'(r_id.size()), 32'd1);
    check("bp_ready_full_again", 32'(req_ready), 32'd0);

    // Drain everything.
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    check("drain_count", 32'(r_id.size()), 32'd5);
    check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
